hex_scan_display: RTL and testbench

//  Time-multiplexed driver for a bank of common-anode 7-segment digits.

---
 rtl/hex_scan_display.sv | 110 +++++++++++
 tb/tb_hex_scan_display.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_display.sv
// Scanned multi-digit common-anode 7-segment driver with frame-synchronous updates.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module hex_scan_display #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter bit HEX_MODE = 1'b0
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [4*DIGITS-1:0]   iValue,
  input  logic                  iLoad,
  output logic [6:0]            oSeg,
  output logic [DIGITS-1:0]     oDig,
  output logic                  oFrame
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [PW-1:0]       presc;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] pending;
  logic [4*DIGITS-1:0] active;
  logic                frame_d;
  logic                tc;
  logic                last;
  logic                boundary;
  logic [3:0]          nib;
  logic                dark;
  logic [6:0]          seg_next;
`ifdef LEADING_ZERO_BLANK_EN
  logic                zero_run;
`endif

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0:    glyph = 7'h3F;
      4'h1:    glyph = 7'h06;
      4'h2:    glyph = 7'h5B;
      4'h3:    glyph = 7'h4F;
      4'h4:    glyph = 7'h66;
      4'h5:    glyph = 7'h6D;
      4'h6:    glyph = 7'h7D;
      4'h7:    glyph = 7'h27;
      4'h8:    glyph = 7'h7F;
      4'h9:    glyph = 7'h67;
      4'hA:    glyph = HEX_MODE ? 7'h77 : 7'h3E;
      4'hB:    glyph = HEX_MODE ? 7'h7C : 7'h3E;
      4'hC:    glyph = HEX_MODE ? 7'h39 : 7'h3E;
      4'hD:    glyph = HEX_MODE ? 7'h5E : 7'h3E;
      4'hE:    glyph = HEX_MODE ? 7'h79 : 7'h3E;
      default: glyph = HEX_MODE ? 7'h71 : 7'h3E;
    endcase
  endfunction

  assign tc       = (presc == PW'(SCAN_DIV - 1));
  assign last     = (idx == IW'(DIGITS - 1));
  assign boundary = tc && last;

  // Leading-zero run is accumulated from the top digit downwards.
  always_comb begin
    nib  = 4'h0;
    dark = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    zero_run = 1'b1;
`endif
    for (int k = DIGITS - 1; k >= 0; k--) begin
`ifdef LEADING_ZERO_BLANK_EN
      zero_run = zero_run && (active[4*k +: 4] == 4'h0);
`endif
      if (idx == IW'(k)) begin
        nib = active[4*k +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        dark = zero_run && (k != 0);
`endif
      end
    end
    seg_next = dark ? 7'h7F : ~glyph(nib);
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      presc   <= '0;
      idx     <= '0;
      pending <= '0;
      active  <= '0;
      frame_d <= 1'b0;
      oSeg    <= 7'h7F;
      oDig    <= '1;
      oFrame  <= 1'b0;
    end else begin
      presc <= tc ? '0 : presc + 1'b1;
      if (tc) begin
        idx <= last ? '0 : idx + 1'b1;
      end
      if (iLoad) begin
        pending <= iValue;
      end
      // A load on the boundary cycle bypasses pending.
      if (boundary) begin
        active <= iLoad ? iValue : pending;
      end
      frame_d <= boundary;
      oDig    <= ~(DIGITS'(1) << idx);
      oSeg    <= seg_next;
      oFrame  <= frame_d;
    end
  end

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display: scan timing, decode, tear-free loads, reset.
module tb_hex_scan_display;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value;
  logic        load;
  logic [6:0]  seg0, seg1, seg_one;
  logic [3:0]  dig0, dig1;
  logic        dig_one;
  logic        frame0, frame1, frame_one;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hex_scan_display #(.DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1'b0)) u0 (
    .iClk(clk), .iRst(rst), .iValue(value), .iLoad(load),
    .oSeg(seg0), .oDig(dig0), .oFrame(frame0)
  );

  hex_scan_display #(.DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1'b1)) u1 (
    .iClk(clk), .iRst(rst), .iValue(value), .iLoad(load),
    .oSeg(seg1), .oDig(dig1), .oFrame(frame1)
  );

  hex_scan_display #(.DIGITS(1), .SCAN_DIV(4), .HEX_MODE(1'b0)) u_one (
    .iClk(clk), .iRst(rst), .iValue(value[3:0]), .iLoad(load),
    .oSeg(seg_one), .oDig(dig_one), .oFrame(frame_one)
  );

  typedef struct {
    logic [15:0]     value;
    logic [3:0][6:0] seg_m0;
    logic [3:0][6:0] seg_m1;
  } vec_t;

  vec_t            vecs[4];
  logic [3:0][6:0] zeros;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Entered at a frame start sample point; leaves at the next one.
  task automatic check_frame(input string name, input logic [3:0][6:0] e0,
                             input logic [3:0][6:0] e1);
    logic [3:0] ed;
    for (int k = 0; k < 4; k++) begin
      ed = ~(4'b0001 << k);
      chk({name, "_dig"}, dig0, ed);
      chk({name, "_dig1"}, dig1, ed);
      chk({name, "_seg_m0"}, seg0, e0[k]);
      chk({name, "_seg_m1"}, seg1, e1[k]);
      chk({name, "_frame"}, frame0, (k == 0));
      tick(4);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  initial begin
    logic [3:0] ed;
    vecs[0] = '{16'h3210, {7'h30, 7'h24, 7'h79, 7'h40},
                          {7'h30, 7'h24, 7'h79, 7'h40}};
    vecs[1] = '{16'h7654, {7'h58, 7'h02, 7'h12, 7'h19},
                          {7'h58, 7'h02, 7'h12, 7'h19}};
    vecs[2] = '{16'hBA98, {7'h41, 7'h41, 7'h18, 7'h00},
                          {7'h03, 7'h08, 7'h18, 7'h00}};
    vecs[3] = '{16'hFEDC, {7'h41, 7'h41, 7'h41, 7'h41},
                          {7'h0E, 7'h06, 7'h21, 7'h46}};
    for (int k = 0; k < 4; k++)
      zeros[k] = (k == 0 || !BLANK) ? 7'h40 : 7'h7F;

    rst   = 1'b1;
    load  = 1'b0;
    value = 16'h0;
    tick(3);
    chk("rst_seg", seg0, 7'h7F);
    chk("rst_dig", dig0, 4'hF);
    chk("rst_frame", frame0, 1'b0);
    rst = 1'b0;

    // Scan rotation and frame pulse from reset release.
    for (int n = 1; n <= 17; n++) begin
      tick();
      ed = ~(4'b0001 << (((n - 1) / 4) % 4));
      chk("scan_dig", dig0, ed);
      chk("scan_frame", frame0, (n == 17));
      chk("one_frame", frame_one, (n > 1) && ((n - 1) % 4 == 0));
      chk("one_dig", dig_one, 1'b0);
      if (n == 1) begin
        chk("first_seg", seg0, 7'h40);
        chk("one_seg", seg_one, 7'h40);
      end
    end

    // Tear-free update while showing 0000.
    chk("tf_d0", seg0, zeros[0]);
    tick(2);
    do_load(16'h1234);
    tick();
    chk("tf_d1", seg0, zeros[1]);
    tick(4);
    chk("tf_d2", seg0, zeros[2]);
    tick(4);
    chk("tf_d3", seg0, zeros[3]);
    tick(4);
    check_frame("tf_new", {7'h79, 7'h24, 7'h30, 7'h19},
                          {7'h79, 7'h24, 7'h30, 7'h19});

    // Multi-load in one frame, then a load on the boundary cycle.
    do_load(16'h1111);
    do_load(16'h2222);
    chk("ml_d0", seg0, 7'h19);
    tick(2);
    chk("ml_dig1", dig0, 4'b1101);
    chk("ml_d1", seg0, 7'h30);
    tick(4);
    chk("ml_d2", seg0, 7'h24);
    tick(4);
    chk("ml_d3", seg0, 7'h79);
    tick(2);
    do_load(16'h3333);
    chk("ml_bnd", seg0, 7'h79);
    tick();
    check_frame("bypass", {4{7'h30}}, {4{7'h30}});
    check_frame("hold", {4{7'h30}}, {4{7'h30}});

    // Decode sweep over the glyph table in both modes.
    for (int i = 0; i < 4; i++) begin
      do_load(vecs[i].value);
      tick(15);
      check_frame($sformatf("dec%0d", i), vecs[i].seg_m0, vecs[i].seg_m1);
    end

    // Reset mid-frame discards a pending load.
    do_load(16'hABCD);
    tick(3);
    rst = 1'b1;
    tick();
    chk("mr_seg", seg0, 7'h7F);
    chk("mr_dig", dig0, 4'hF);
    chk("mr_frame", frame0, 1'b0);
    chk("mr_seg1", seg1, 7'h7F);
    rst = 1'b0;
    tick();
    chk("mr_rel_dig", dig0, 4'b1110);
    chk("mr_rel_seg", seg0, 7'h40);
    chk("mr_rel_frame", frame0, 1'b0);
    tick(16);
    check_frame("mr_resume", zeros, zeros);

`ifdef LEADING_ZERO_BLANK_EN
    do_load(16'h0050);
    tick(15);
    check_frame("lzb_50", {7'h7F, 7'h7F, 7'h12, 7'h40},
                          {7'h7F, 7'h7F, 7'h12, 7'h40});
    do_load(16'h0000);
    tick(15);
    check_frame("lzb_00", {7'h7F, 7'h7F, 7'h7F, 7'h40},
                          {7'h7F, 7'h7F, 7'h7F, 7'h40});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
